// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared types and constants for the ALU control unit: ALU op codes,
// RV32I opcode/funct7 constants and the controller state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_EQ   = 4'd5,  // reserved for the branch unit, never produced by decode
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11
  } alu_op_t;

  localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE   = 7'b0010011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    WB,
    ERR
  } ctrl_state_t;

  // Op selected by funct3 when funct7 is the base encoding (shift-right is SRL)
  function automatic alu_op_t base_op(input logic [2:0] funct3);
    alu_op_t op;
    unique case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// Instruction handshake plus ALU / register-file control bundle.
// The controller uses the slave modport; whatever feeds instructions and
// supplies the ALU result uses the master modport.
interface alu_ctrl_fsm_if
  import alu_pkg::*;
#(
  parameter int XLEN = 32
);

  logic [31:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            hold;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  alu_op_t         alu_op;
  logic            alu_src_imm;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_wdata;
  logic            rd_we;
  logic            done;
  logic            illegal;

  modport master (
    output instr, instr_valid, hold, alu_result,
    input  instr_ready, rs1_addr, rs2_addr, alu_op, alu_src_imm, imm,
           rd_addr, rd_wdata, rd_we, done, illegal
  );

  modport slave (
    input  instr, instr_valid, hold, alu_result,
    output instr_ready, rs1_addr, rs2_addr, alu_op, alu_src_imm, imm,
           rd_addr, rd_wdata, rd_we, done, illegal
  );

endinterface

// File: rtl/alu_ctrl_fsm_decoder.sv
// Combinational RV32I ALU instruction decoder: R-type and I-type arithmetic
// only. Anything else, including reserved funct7 encodings, flags illegal.
module alu_decoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output alu_op_t         alu_op_o,
  output logic            alu_src_imm_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_reg_fields;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Register addresses are taken straight from the latched word by the FSM
  assign unused_reg_fields = ^{instr_i[19:15], instr_i[11:7]};

  // Map opcode/funct3/funct7 to op, operand-B source and immediate
  always_comb begin
    alu_op_o      = ALU_ADD;
    alu_src_imm_o = 1'b0;
    imm_o         = '0;
    illegal_o     = 1'b0;
    unique case (opcode)
      OPC_RTYPE: begin
        if (funct7 == FUNCT7_BASE) begin
          alu_op_o = base_op(funct3);
        end else if (funct7 == FUNCT7_ALT) begin
          if (funct3 == 3'b000) begin
            alu_op_o = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            alu_op_o = ALU_SRA;
          end else begin
            illegal_o = 1'b1;
          end
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_ITYPE: begin
        alu_src_imm_o = 1'b1;
        if (funct3 == 3'b001) begin
          alu_op_o  = ALU_SLL;
          imm_o     = {{(XLEN-5){1'b0}}, instr_i[24:20]};
          illegal_o = (funct7 != FUNCT7_BASE);
        end else if (funct3 == 3'b101) begin
          imm_o = {{(XLEN-5){1'b0}}, instr_i[24:20]};
          if (funct7 == FUNCT7_BASE) begin
            alu_op_o = ALU_SRL;
          end else if (funct7 == FUNCT7_ALT) begin
            alu_op_o = ALU_SRA;
          end else begin
            illegal_o = 1'b1;
          end
        end else begin
          alu_op_o = base_op(funct3);
          imm_o    = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        end
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU control unit: IDLE -> DECODE -> EXEC -> WB (or DECODE ->
// ERR on an unsupported encoding). One instruction in flight at a time;
// hold freezes everything outside IDLE.
// Optional feature macro: ALU_CTRL_PERF_CNT_EN adds retired_cnt/illegal_cnt.
module alu_ctrl_fsm
  import alu_pkg::*;
#(
  parameter int XLEN = 32
`ifdef ALU_CTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_fsm_if.slave bus
`ifdef ALU_CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0] retired_cnt
  , output logic [CNT_W-1:0] illegal_cnt
`endif
);

  ctrl_state_t     state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  alu_op_t         alu_op_q, alu_op_d;
  logic            src_imm_q, src_imm_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] result_q, result_d;

  alu_op_t         dec_op;
  logic            dec_src_imm;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  alu_decoder #(.XLEN(XLEN)) u_decoder (
    .instr_i      (instr_q),
    .alu_op_o     (dec_op),
    .alu_src_imm_o(dec_src_imm),
    .imm_o        (dec_imm),
    .illegal_o    (dec_illegal)
  );

  // State and pipeline registers; reset discards any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      alu_op_q  <= ALU_ADD;
      src_imm_q <= 1'b0;
      imm_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_op_q  <= alu_op_d;
      src_imm_q <= src_imm_d;
      imm_q     <= imm_d;
      result_q  <= result_d;
    end
  end

  // Next state and register updates; hold keeps every register as-is
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_op_d  = alu_op_q;
    src_imm_d = src_imm_q;
    imm_d     = imm_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!bus.hold) begin
          alu_op_d  = dec_op;
          src_imm_d = dec_src_imm;
          imm_d     = dec_imm;
          state_d   = dec_illegal ? ERR : EXEC;
        end
      end
      EXEC: begin
        if (!bus.hold) begin
          result_d = bus.alu_result;
          state_d  = WB;
        end
      end
      WB: begin
        if (!bus.hold) state_d = IDLE;
      end
      ERR: begin
        if (!bus.hold) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.rs1_addr    = instr_q[19:15];
  assign bus.rs2_addr    = instr_q[24:20];
  assign bus.rd_addr     = instr_q[11:7];
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_src_imm = src_imm_q;
  assign bus.imm         = imm_q;
  assign bus.rd_wdata    = result_q;
  assign bus.rd_we       = (state_q == WB) && (instr_q[11:7] != 5'd0);
  assign bus.done        = (state_q == WB);
  assign bus.illegal     = (state_q == ERR);

`ifdef ALU_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_cnt_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  // Count each instruction once, on the cycle it leaves WB/ERR, even if held there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (state_q == WB && !bus.hold)  retired_cnt_q <= retired_cnt_q + CNT_W'(1);
      if (state_q == ERR && !bus.hold) illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Testbench for alu_ctrl_fsm: per-scenario tasks with inline timing checks
// plus a scoreboard that matches every done/illegal/rd_we event against the
// result expected when the instruction was issued.
module tb_alu_ctrl_fsm;
  import alu_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic            ill;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  exp_t sbq[$];
  exp_t mon_e;

  alu_ctrl_fsm_if #(.XLEN(XLEN)) bus ();

`ifdef ALU_CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] illegal_cnt;
`endif

  alu_ctrl_fsm #(.XLEN(XLEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef ALU_CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
    , .illegal_cnt(illegal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every visible output event must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (bus.done || bus.illegal || bus.rd_we)) begin
      total++;
      if (sbq.size() == 0) begin
        $display("[TB] FAIL sb_unexpected: done=%0b illegal=%0b rd_we=%0b, required no event",
                 bus.done, bus.illegal, bus.rd_we);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.ill) begin
          if ({bus.illegal, bus.done, bus.rd_we} !== 3'b100)
            $display("[TB] FAIL sb_illegal: ill/done/we=%b, required 100",
                     {bus.illegal, bus.done, bus.rd_we});
          else passed++;
        end else begin
          if ({bus.illegal, bus.done, bus.rd_we, bus.rd_addr, bus.rd_wdata} !==
              {1'b0, 1'b1, mon_e.we, mon_e.rd, mon_e.wd})
            $display("[TB] FAIL sb_retire: ill=%0b done=%0b we=%0b rd=%0d wd=%h, required 0 1 %0b %0d %h",
                     bus.illegal, bus.done, bus.rd_we, bus.rd_addr, bus.rd_wdata,
                     mon_e.we, mon_e.rd, mon_e.wd);
          else passed++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Wait (bounded) for ready, present one instruction for exactly one handshake
  task automatic issue(input logic [31:0] ins, input logic [XLEN-1:0] res);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) begin
      total++;
      $display("[TB] FAIL issue_ready: ready=%0b after 20 cycles, required 1", bus.instr_ready);
    end
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    bus.alu_result  = res;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic push_ok(input logic [4:0] rd, input logic [XLEN-1:0] wd);
    exp_t e;
    e.ill = 1'b0;
    e.we  = (rd != 5'd0);
    e.rd  = rd;
    e.wd  = wd;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.hold        = 1'b0;
    bus.alu_result  = '0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.instr_ready, bus.done, bus.illegal, bus.rd_we, bus.alu_src_imm} !== 5'b10000)
      $display("[TB] FAIL reset_ctrl: rdy/done/ill/we/src=%b, required 10000",
               {bus.instr_ready, bus.done, bus.illegal, bus.rd_we, bus.alu_src_imm});
    else passed++;
    total++;
    if ({bus.alu_op, bus.imm, bus.rd_wdata, bus.rs1_addr, bus.rs2_addr, bus.rd_addr} !== '0)
      $display("[TB] FAIL reset_data: op=%0d imm=%h wd=%h rs1=%0d rs2=%0d rd=%0d, required all 0",
               bus.alu_op, bus.imm, bus.rd_wdata, bus.rs1_addr, bus.rs2_addr, bus.rd_addr);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    push_ok(5'd3, 32'h5);
    issue(32'h002081B3, 32'h5);
    @(negedge clk);
    total++;
    if (bus.instr_ready !== 1'b0)
      $display("[TB] FAIL add_ready_c1: ready=%0b, required 0", bus.instr_ready);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.alu_op, bus.alu_src_imm, bus.rs1_addr, bus.rs2_addr, bus.rd_addr} !==
        {4'd0, 1'b0, 5'd1, 5'd2, 5'd3})
      $display("[TB] FAIL add_exec: op=%0d src=%0b rs1=%0d rs2=%0d rd=%0d, required 0 0 1 2 3",
               bus.alu_op, bus.alu_src_imm, bus.rs1_addr, bus.rs2_addr, bus.rd_addr);
    else passed++;
    total++;
    if (bus.done !== 1'b0)
      $display("[TB] FAIL add_done_c2: done=%0b, required 0", bus.done);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.rd_we, bus.done} !== 2'b11)
      $display("[TB] FAIL add_wb_c3: we/done=%b, required 11", {bus.rd_we, bus.done});
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.instr_ready, bus.done, bus.rd_we} !== 3'b100)
      $display("[TB] FAIL add_c4: rdy/done/we=%b, required 100",
               {bus.instr_ready, bus.done, bus.rd_we});
    else passed++;
  endtask

  // Legal encodings: instr, rd, op, src_imm, imm
  task automatic test_decode();
    logic [31:0] ins_t [9];
    logic [4:0]  rd_t  [9];
    logic [3:0]  op_t  [9];
    logic        src_t [9];
    logic [31:0] imm_t [9];
    ins_t = '{32'h407302B3, 32'hFFF00093, 32'h40325213, 32'h7F01F113, 32'h8000C093,
              32'h003130B3, 32'h4020D1B3, 32'h01F09093, 32'hFFF12093};
    rd_t  = '{5'd5, 5'd1, 5'd4, 5'd2, 5'd1, 5'd1, 5'd3, 5'd1, 5'd1};
    op_t  = '{4'd1, 4'd0, 4'd11, 4'd2, 4'd4, 4'd8, 4'd11, 4'd9, 4'd6};
    src_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    imm_t = '{32'h0, 32'hFFFFFFFF, 32'h3, 32'h7F0, 32'hFFFFF800,
              32'h0, 32'h0, 32'h1F, 32'hFFFFFFFF};
    for (int i = 0; i < 9; i++) begin
      logic [31:0] res;
      res = 32'hA000_0000 + 32'(i * 17);
      push_ok(rd_t[i], res);
      issue(ins_t[i], res);
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({bus.alu_op, bus.alu_src_imm, bus.imm} !== {op_t[i], src_t[i], imm_t[i]})
        $display("[TB] FAIL decode_%0d: op=%0d src=%0b imm=%h, required %0d %0b %h",
                 i, bus.alu_op, bus.alu_src_imm, bus.imm, op_t[i], src_t[i], imm_t[i]);
      else passed++;
      if (i == 1) begin
        total++;
        if ({bus.rs1_addr, bus.rd_addr} !== {5'd0, 5'd1})
          $display("[TB] FAIL addi_addr: rs1=%0d rd=%0d, required 0 1", bus.rs1_addr, bus.rd_addr);
        else passed++;
      end
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins_t [5];
    ins_t = '{32'h00000000, 32'h02208033, 32'h40109093, 32'h4020C0B3, 32'h2020D093};
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.ill = 1'b1;
      e.we  = 1'b0;
      e.rd  = '0;
      e.wd  = '0;
      sbq.push_back(e);
      issue(ins_t[i], 32'hDEAD0000);
      @(negedge clk);
      total++;
      if (bus.illegal !== 1'b0)
        $display("[TB] FAIL illegal_c1_%0d: illegal=%0b, required 0", i, bus.illegal);
      else passed++;
      @(negedge clk);
      total++;
      if ({bus.illegal, bus.done, bus.rd_we} !== 3'b100)
        $display("[TB] FAIL illegal_c2_%0d: ill/done/we=%b, required 100",
                 i, {bus.illegal, bus.done, bus.rd_we});
      else passed++;
      @(negedge clk);
      total++;
      if ({bus.instr_ready, bus.illegal} !== 2'b10)
        $display("[TB] FAIL illegal_c3_%0d: rdy/ill=%b, required 10",
                 i, {bus.instr_ready, bus.illegal});
      else passed++;
    end
  endtask

  task automatic test_add_x0();
    push_ok(5'd0, 32'h77);
    issue(32'h00208033, 32'h77);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.done, bus.rd_we} !== 2'b10)
      $display("[TB] FAIL add_x0: done/we=%b, required 10", {bus.done, bus.rd_we});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    push_ok(5'd1, 32'h0000_0111);
    push_ok(5'd5, 32'h0000_1234);
    @(negedge clk);
    bus.instr       = 32'hFFF00093;
    bus.instr_valid = 1'b1;
    bus.alu_result  = 32'h0000_0111;
    @(posedge clk);
    #1;
    bus.instr = 32'h407302B3;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.instr_ready !== 1'b0)
        $display("[TB] FAIL b2b_ready_c%0d: ready=%0b, required 0", c, bus.instr_ready);
      else passed++;
    end
    @(posedge clk);
    #1;
    bus.alu_result = 32'h0000_1234;
    @(negedge clk);
    total++;
    if (bus.instr_ready !== 1'b1)
      $display("[TB] FAIL b2b_ready_c4: ready=%0b, required 1", bus.instr_ready);
    else passed++;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.alu_op !== ALU_SUB)
      $display("[TB] FAIL b2b_op: op=%0d, required 1", bus.alu_op);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.done !== 1'b1)
      $display("[TB] FAIL b2b_done_c7: done=%0b, required 1", bus.done);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_hold();
    push_ok(5'd7, 32'hCAFE_F00D);
    issue(32'h002083B3, 32'hCAFE_F00D);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.hold = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if ({bus.done, bus.instr_ready} !== 2'b00)
        $display("[TB] FAIL hold_c%0d: done/rdy=%b, required 00", c, {bus.done, bus.instr_ready});
      else passed++;
    end
    @(posedge clk);
    #1;
    bus.hold = 1'b0;
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0)
      $display("[TB] FAIL hold_c6: done=%0b, required 0", bus.done);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.done, bus.rd_we} !== 2'b11)
      $display("[TB] FAIL hold_c7: done/we=%b, required 11", {bus.done, bus.rd_we});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    issue(32'h407302B3, 32'h5555_AAAA);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.instr_ready, bus.rd_we, bus.done, bus.alu_op} !== {3'b100, 4'd0})
      $display("[TB] FAIL rst_mid: rdy/we/done=%b op=%0d, required 100 0",
               {bus.instr_ready, bus.rd_we, bus.done}, bus.alu_op);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({bus.rd_we, bus.done, bus.instr_ready} !== 3'b001)
        $display("[TB] FAIL rst_after_%0d: we/done/rdy=%b, required 001",
                 c, {bus.rd_we, bus.done, bus.instr_ready});
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_add();
    test_decode();
    test_illegal();
    test_add_x0();
    test_back_to_back();
    test_hold();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    total++;
    if (sbq.size() != 0)
      $display("[TB] FAIL sb_drain: %0d expectations left, required 0", sbq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
